// File: rtl/fraction_reducer_pkg.sv
// Shared definitions for the fraction reducer: FSM state encoding and
// default parameter values used by the top level and the divider.
package fraction_reducer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DIV  = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam int W_DEF           = 16;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/fraction_reducer_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first step is taken on the go cycle itself, so W steps complete after W
// edges and valid pulses for one cycle in the cycle after the last step.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go                1-cycle start; dividend/divisor sampled with it
//   dividend, divisor W-bit unsigned operands
//   busy              high while steps remain
//   valid             1-cycle pulse when quot/rem are final
//   quot, rem         W-bit quotient and remainder (held until next go)
import fraction_reducer_pkg::*;

module seq_divider #(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_q, q_q, d_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  src_r, src_q, src_d, nr, nq;
    logic [W:0]    trial;

    // One restoring step; on go the operands come straight from the inputs.
    always_comb begin
        src_r = go ? '0 : r_q;
        src_q = go ? dividend : q_q;
        src_d = go ? divisor : d_q;
        trial = {src_r, src_q[W-1]};
        if (trial >= {1'b0, src_d}) begin
            nr = W'(trial - {1'b0, src_d});
            nq = {src_q[W-2:0], 1'b1};
        end else begin
            nr = trial[W-1:0];
            nq = {src_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (go) begin
                r_q  <= nr;
                q_q  <= nq;
                d_q  <= divisor;
                cnt  <= CW'(W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                r_q <= nr;
                q_q <= nq;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign quot = q_q;
    assign rem  = r_q;

endmodule

// File: rtl/fraction_reducer.sv
// fraction_reducer: reduces num/den to lowest terms. Requests gcd(num,den)
// from an external GCD engine, then divides both operands by it with two
// parallel seq_divider instances.
// Optional feature: define REDUCER_TIMEOUT_EN to bound the GCD wait to
// TIMEOUT_CYC cycles (err=1, outputs = original operands on expiry).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num, den     request; sampled only in IDLE
//   busy                high outside IDLE
//   done, err           1-cycle result pulse; err flags den==0, gcd==0 or timeout
//   num_out, den_out    reduced fraction, held until reloaded
//   gcd_start, gcd_a/b  master side of the GCD handshake
//   gcd_done, gcd_in    GCD completion level and result
import fraction_reducer_pkg::*;

module fraction_reducer #(
    parameter int W           = W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] num_out,
    output logic [W-1:0] den_out,
    output logic         gcd_start,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_in
);
    state_t       state, state_n;
    logic [W-1:0] n_r, d_r;
    logic         err_r;
    logic         div_go, tmo_hit;
    logic         nbusy, dbusy, nvalid, dvalid;
    logic [W-1:0] q_n, q_d, rem_n, rem_d;

`ifdef REDUCER_TIMEOUT_EN
    localparam int TW = (W > $clog2(TIMEOUT_CYC + 1)) ? W : $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state == REQ) tmo_cnt <= '0;
        else if (state == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Last WAIT cycle of the allowed window; gcd_done still wins if it arrives here.
    assign tmo_hit = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Dividers are loaded on the same edge that enters DIV.
    assign div_go    = (state == WAIT) && gcd_done && (gcd_in != '0);
    assign busy      = (state != IDLE);
    assign gcd_start = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = (den == '0 || num == '0) ? FIN : REQ;
            REQ:  state_n = WAIT;
            WAIT: begin
                if (gcd_done)     state_n = (gcd_in == '0) ? FIN : DIV;
                else if (tmo_hit) state_n = FIN;
            end
            DIV:  if (nvalid) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // done/err are registered off FIN, so they appear the cycle after FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r     <= '0;
            d_r     <= '0;
            err_r   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            num_out <= '0;
            den_out <= '0;
            gcd_a   <= '0;
            gcd_b   <= '0;
        end else begin
            done <= (state == FIN);
            err  <= (state == FIN) && err_r;
            case (state)
                IDLE: if (start) begin
                    n_r   <= num;
                    d_r   <= den;
                    err_r <= 1'b0;
                    if (den == '0) begin
                        err_r   <= 1'b1;
                        num_out <= num;
                        den_out <= '0;
                    end else if (num == '0) begin
                        num_out <= '0;
                        den_out <= W'(1);
                    end else begin
                        gcd_a <= num;
                        gcd_b <= den;
                    end
                end
                WAIT: if ((gcd_done && gcd_in == '0) || (!gcd_done && tmo_hit)) begin
                    err_r   <= 1'b1;
                    num_out <= n_r;
                    den_out <= d_r;
                end
                DIV: if (nvalid) begin
                    num_out <= q_n;
                    den_out <= q_d;
                end
                default: ;
            endcase
        end
    end

    seq_divider #(.W(W)) u_div_num (
        .clk(clk), .rst(rst), .go(div_go), .dividend(n_r), .divisor(gcd_in),
        .busy(nbusy), .valid(nvalid), .quot(q_n), .rem(rem_n)
    );

    seq_divider #(.W(W)) u_div_den (
        .clk(clk), .rst(rst), .go(div_go), .dividend(d_r), .divisor(gcd_in),
        .busy(dbusy), .valid(dvalid), .quot(q_d), .rem(rem_d)
    );

    // A correct GCD divides both operands exactly; anything else is an upstream bug.
    always_ff @(posedge clk) begin
        if (!rst && state == DIV && nvalid)
            assert (dvalid && !nbusy && !dbusy && rem_n == '0 && rem_d == '0);
    end

endmodule

// File: tb/tb_fraction_reducer.sv
module tb_fraction_reducer;
    localparam int W   = 16;
    localparam int TMO = 64;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] num = '0, den = '0;
    logic         busy, done, err, gcd_start, gcd_done;
    logic [W-1:0] num_out, den_out, gcd_a, gcd_b, gcd_in;

    fraction_reducer #(.W(W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .num(num), .den(den),
        .busy(busy), .done(done), .err(err), .num_out(num_out), .den_out(den_out),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_done(gcd_done), .gcd_in(gcd_in)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural GCD engine: answers G cycles after gcd_start.
    int unsigned  g_lat = 1;
    bit           g_never = 1'b0;
    bit           pend = 1'b0;
    int unsigned  g_rem = 0;
    logic [W-1:0] g_res = '0;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != '0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    always @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else if (gcd_start) begin
            pend  <= 1'b1;
            g_rem <= g_lat - 1;
            g_res <= gcd_f(gcd_a, gcd_b);
        end else if (gcd_done) pend <= 1'b0;
        else if (pend && g_rem != 0) g_rem <= g_rem - 1;
    end

    assign gcd_done = pend && (g_rem == 0) && !g_never;
    assign gcd_in   = g_res;

    // Scoreboard
    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic         e;
        int unsigned  t0;
        int unsigned  lat;
    } exp_t;
    exp_t sb[$];
    logic [W-1:0] exp_a = '0, exp_b = '0;
    int gs_cnt = 0;

    always @(negedge clk) begin
        if (gcd_start) gs_cnt++;
        if (!rst && pend) begin
            chk("gcd_a_hold", 32'(gcd_a), 32'(exp_a));
            chk("gcd_b_hold", 32'(gcd_b), 32'(exp_b));
        end
        if (done) begin
            if (sb.size() == 0) chk("spurious_done", 32'(done), 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("num_out", 32'(num_out), 32'(e.n));
                chk("den_out", 32'(den_out), 32'(e.d));
                chk("err", 32'(err), 32'(e.e));
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d, input int unsigned g,
                         input logic [W-1:0] en, input logic [W-1:0] ed, input logic ee,
                         input int unsigned lat);
        @(posedge clk); #1;
        sb.push_back('{en, ed, ee, cyc, lat});
        exp_a = n; exp_b = d; g_lat = g;
        num = n; den = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic pulse_ignored(input logic [W-1:0] n, input logic [W-1:0] d);
        num = n; den = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_err"}, 32'(err), 0);
        chk({nm, "_num_out"}, 32'(num_out), 0);
        chk({nm, "_den_out"}, 32'(den_out), 0);
        chk({nm, "_gcd_start"}, 32'(gcd_start), 0);
        chk({nm, "_gcd_a"}, 32'(gcd_a), 0);
        chk({nm, "_gcd_b"}, 32'(gcd_b), 0);
    endtask

    initial begin
        int gs0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // 1: 12/18, G=5 -> 2/3, latency 2+5+16+1
        issue(12, 18, 5, 2, 3, 0, 24);
        drain(100);
        // 2: 75/90, G=3 -> 5/6 (operand hold checked by monitor)
        issue(75, 90, 3, 5, 6, 0, 22);
        drain(100);
        // 3: coprime, then zero numerator without a GCD request
        issue(7, 13, 1, 7, 13, 0, 20);
        drain(100);
        gs0 = gs_cnt;
        issue(0, 7, 1, 0, 1, 0, 2);
        drain(20);
        // 4: zero denominator
        issue(5, 0, 1, 5, 0, 1, 2);
        drain(20);
        chk("no_gcd_request", 32'(gs_cnt), 32'(gs0));
        // 5a: starts during WAIT and DIV are ignored
        issue(8, 12, 6, 2, 3, 0, 25);
        repeat (2) @(posedge clk);
        #1;
        pulse_ignored(1, 1);
        repeat (6) @(posedge clk);
        #1;
        pulse_ignored(40, 60);
        drain(100);
        // 5b: reset mid-DIV clears everything, then 9/3 -> 3/1
        issue(30, 45, 2, 2, 3, 0, 21);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("mid_reset");
        rst = 1'b0;
        sb.delete();
        issue(9, 3, 3, 3, 1, 0, 22);
        drain(100);
`ifdef REDUCER_TIMEOUT_EN
        // 6: engine never answers -> err with original operands
        g_never = 1'b1;
        issue(21, 14, 1, 21, 14, 1, TMO + 3);
        drain(TMO + 50);
        g_never = 1'b0;
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
